spike_encoder: RTL and testbench
================================

SPIKE_ENCODER -- requirements
Module: spike_encoder

Interface
REQ-001 The module SHALL have parameter NUM_SPIKES, default 16, giving the number of encoded input channels; it drives the spikes_in width of the downstream neuron array.
REQ-002 The module SHALL have parameter TBITS, default 3, giving the time-step/intensity width; gamma window = 2^TBITS steps, MAX = 2^TBITS-1.
REQ-003 The module SHALL have parameter HOLD, default 0: 0 = single-cycle spike pulse; 1 = spike held high from its fire step to frame end.
REQ-004 The module SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port start, input, 1 bit: frame request, accepted when start=1 and ready=1.
REQ-007 The module SHALL have port intensity, input, [NUM_SPIKES-1:0][TBITS-1:0]: per-channel unsigned intensity, sampled only on accept.
REQ-008 The module SHALL have port stall, input, 1 bit: when 1 in RUN, freeze step and outputs.
REQ-009 The module SHALL have port ready, output, 1 bit: 1 only in IDLE.
REQ-010 The module SHALL have port spike_valid, output, 1 bit: 1 only in RUN; spikes_out meaningful.
REQ-011 The module SHALL have port spikes_out, output, [NUM_SPIKES-1:0]: registered spike vector, bit i = channel i.
REQ-012 The module SHALL have port step, output, [TBITS-1:0]: current time step within the gamma window.
REQ-013 The module SHALL have port frame_done, output, 1 bit: single-cycle pulse after the last step.

Function
REQ-014 The FSM SHALL have two states, IDLE and RUN; IDLE -> RUN on accept; RUN -> IDLE when step==MAX and stall=0.
REQ-015 On accept in cycle T, the block SHALL register all intensities; cycle T+1 SHALL be RUN with step=0 and spike_valid=1.
REQ-016 Spike time of channel i SHALL be t_i = MAX - intensity[i] (higher intensity fires earlier); intensity 0 SHALL never fire.
REQ-017 HOLD=0: spikes_out[i] SHALL be 1 exactly in the RUN cycle(s) where step==t_i, else 0.
REQ-018 HOLD=1: spikes_out[i] SHALL be 1 in every RUN cycle with step>=t_i, else 0.
REQ-019 In RUN with stall=0, step SHALL increment by 1 per cycle, no wrap (leaves RUN after MAX).
REQ-020 In RUN with stall=1, step, spikes_out and state SHALL hold their values; a stalled step==t_i SHALL keep the HOLD=0 pulse high for the whole stall.
REQ-021 The cycle after the last RUN cycle SHALL be IDLE with frame_done=1, spikes_out=0, spike_valid=0, step=0, ready=1; frame_done SHALL be 0 in all other cycles.
REQ-022 A frame SHALL occupy exactly 2^TBITS RUN cycles plus stalled cycles; start while not ready SHALL be ignored with no effect on captured intensities.
REQ-023 Back-to-back: start=1 in the frame_done cycle SHALL be accepted (ready=1), next RUN beginning the following cycle.
REQ-024 In IDLE, spikes_out SHALL be 0 and stall SHALL have no effect.
REQ-025 All outputs SHALL be driven from registers (no combinational path input->output).

Reset
REQ-026 With rst=1 at a clock edge, state SHALL become IDLE, step=0, spikes_out=0, spike_valid=0, frame_done=0, ready=1, captured intensities=0.
REQ-027 rst SHALL take priority over start and stall in the same cycle; reset mid-RUN SHALL abort the frame without a frame_done pulse.

Verification
REQ-028 Pulse mode: NUM_SPIKES=4, TBITS=3, HOLD=0, intensity={i3:1,i2:3,i1:0,i0:7}, start at T -> spikes_out 4'b0001 at T+1, 4'b0100 at T+5, 4'b1000 at T+7, 0 elsewhere; frame_done at T+9.
REQ-029 Hold mode: same stimulus, HOLD=1 -> spikes_out 0001 at T+1..T+4, 0101 at T+5..T+6, 1101 at T+7..T+8, 0000 at T+9.
REQ-030 Stall: stall=1 for 3 cycles while step=4, HOLD=0 -> spikes_out 0100 for 4 cycles total, frame_done delayed to T+12.
REQ-031 Ignored start: start pulses at T+3 with new intensities -> outputs unchanged from REQ-028, ready=0 through T+8.
REQ-032 Reset mid-frame: rst at T+4 -> next cycle IDLE, spikes_out=0, ready=1, no frame_done; subsequent start runs normally.
REQ-033 Back-to-back: start held high -> frames accepted at T and T+9, second frame's step=0 at T+10, all intensities 0 -> spikes_out=0 for whole frame.

Source files
------------

// File: rtl/spike_encoder.sv
// Time-to-first-spike (gamma) encoder: converts per-channel intensities into
// spike times within a 2^TBITS-step window; brighter channels fire earlier.
module spike_encoder #(
  parameter int NUM_SPIKES = 16,
  parameter int TBITS      = 3,
  parameter bit HOLD       = 1'b0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [NUM_SPIKES-1:0][TBITS-1:0]    intensity,
  input  logic                                stall,
  output logic                                ready,
  output logic                                spike_valid,
  output logic [NUM_SPIKES-1:0]               spikes_out,
  output logic [TBITS-1:0]                    step,
  output logic                                frame_done
);

  localparam logic [TBITS-1:0] MAX    = '1;
  localparam logic [0:0]       S_IDLE = 1'b0;
  localparam logic [0:0]       S_RUN  = 1'b1;

  logic [0:0]                          state_q, state_d;
  logic [TBITS-1:0]                    step_q, step_d;
  logic [NUM_SPIKES-1:0]               spikes_q, spikes_d;
  logic                                valid_q, valid_d;
  logic                                done_q, done_d;
  logic                                ready_q, ready_d;
  logic [NUM_SPIKES-1:0][TBITS-1:0]    int_q, int_d;

  // Spike vector for a given step; intensity 0 maps to "never fire".
  function automatic logic [NUM_SPIKES-1:0] fire(
    input logic [NUM_SPIKES-1:0][TBITS-1:0] iv,
    input logic [TBITS-1:0]                 s
  );
    logic [NUM_SPIKES-1:0] f;
    logic [TBITS-1:0]      t;
    f = '0;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      t = MAX - iv[i];
      if (iv[i] != '0) begin
        f[i] = HOLD ? (s >= t) : (s == t);
      end
    end
    return f;
  endfunction

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    spikes_d = spikes_q;
    valid_d  = valid_q;
    done_d   = 1'b0;
    ready_d  = ready_q;
    int_d    = int_q;
    case (state_q)
      S_IDLE: begin
        step_d   = '0;
        spikes_d = '0;
        valid_d  = 1'b0;
        ready_d  = 1'b1;
        if (start) begin
          int_d    = intensity;
          state_d  = S_RUN;
          valid_d  = 1'b1;
          ready_d  = 1'b0;
          spikes_d = fire(intensity, '0);
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (step_q == MAX) begin
            state_d  = S_IDLE;
            step_d   = '0;
            spikes_d = '0;
            valid_d  = 1'b0;
            ready_d  = 1'b1;
            done_d   = 1'b1;
          end else begin
            step_d   = step_q + TBITS'(1);
            spikes_d = fire(int_q, step_q + TBITS'(1));
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      spikes_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      int_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      spikes_q <= spikes_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      int_q    <= int_d;
    end
  end

  assign ready       = ready_q;
  assign spike_valid = valid_q;
  assign spikes_out  = spikes_q;
  assign step        = step_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Scoreboard bench for spike_encoder: pulse (HOLD=0) and hold (HOLD=1)
// instances share stimulus; a monitor checks every valid/frame_done cycle.
module tb_spike_encoder;

  logic            clk = 1'b0;
  logic            rst, start, stall;
  logic [3:0][2:0] intensity;

  logic       ready0, valid0, fd0, ready1, valid1, fd1;
  logic [3:0] spk0, spk1;
  logic [2:0] step0, step1;

  always #5 clk = ~clk;

  spike_encoder #(.NUM_SPIKES(4), .TBITS(3), .HOLD(1'b0)) dut_pulse (
    .clk(clk), .rst(rst), .start(start), .intensity(intensity), .stall(stall),
    .ready(ready0), .spike_valid(valid0), .spikes_out(spk0), .step(step0),
    .frame_done(fd0));

  spike_encoder #(.NUM_SPIKES(4), .TBITS(3), .HOLD(1'b1)) dut_hold (
    .clk(clk), .rst(rst), .start(start), .intensity(intensity), .stall(stall),
    .ready(ready1), .spike_valid(valid1), .spikes_out(spk1), .step(step1),
    .frame_done(fd1));

  typedef struct packed {
    logic [3:0] s0;
    logic [3:0] s1;
    logic [2:0] st;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // intensity {i3:1, i2:3, i1:0, i0:7} -> fire steps i0:0, i2:4, i3:6
  localparam logic [11:0] INT_A = {3'd1, 3'd3, 3'd0, 3'd7};

  logic [3:0] pulse_a [8]  = '{4'b0001, 4'b0000, 4'b0000, 4'b0000,
                               4'b0100, 4'b0000, 4'b1000, 4'b0000};
  logic [3:0] hold_a  [8]  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0101, 4'b0101, 4'b1101, 4'b1101};
  logic [2:0] step_s  [11] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4,
                               3'd5, 3'd6, 3'd7};
  logic [3:0] pulse_s [11] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0100,
                               4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b1000,
                               4'b0000};
  logic [3:0] hold_s  [11] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0101,
                               4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b1101,
                               4'b1101};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] s0, input logic [3:0] s1,
                      input logic [2:0] st, input logic fd);
    exp_t e;
    e.s0 = s0; e.s1 = s1; e.st = st; e.fd = fd;
    q.push_back(e);
  endtask

  task automatic push_frame_a();
    for (int s = 0; s < 8; s++) push(pulse_a[s], hold_a[s], 3'(s), 1'b0);
    push(4'b0000, 4'b0000, 3'd0, 1'b1);
  endtask

  // Monitor: every cycle either instance presents output is scored in order.
  always @(negedge clk) begin
    if (valid0 || fd0 || valid1 || fd1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got valid=%0b fd=%0b spk=%0h want no output at %0t",
                 valid0, fd0, spk0, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("mon_spikes_pulse", 32'(spk0), 32'(e.s0));
        chk("mon_spikes_hold",  32'(spk1), 32'(e.s1));
        chk("mon_step_pulse",   32'(step0), 32'(e.st));
        chk("mon_step_hold",    32'(step1), 32'(e.st));
        chk("mon_done_pulse",   32'(fd0), 32'(e.fd));
        chk("mon_done_hold",    32'(fd1), 32'(e.fd));
        chk("mon_valid_pulse",  32'(valid0), 32'(!e.fd));
        chk("mon_valid_hold",   32'(valid1), 32'(!e.fd));
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; intensity = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready",  32'(ready0 & ready1), 32'd1);
    chk("rst_valid",  32'(valid0 | valid1), 32'd0);
    chk("rst_spikes", 32'(spk0 | spk1), 32'd0);
    chk("rst_step",   32'(step0 | step1), 32'd0);
    chk("rst_done",   32'(fd0 | fd1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame with an ignored start (new intensities) at T+3.
    push_frame_a();
    chk("a_ready_T", 32'(ready0), 32'd1);
    start = 1'b1; intensity = INT_A;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 3) begin start = 1'b1; intensity = {4{3'd7}}; end
      if (k == 4) start = 1'b0;
      chk("a_ready_pulse", 32'(ready0), 32'(k == 9));
      chk("a_ready_hold",  32'(ready1), 32'(k == 9));
    end
    repeat (2) @(negedge clk);

    // Stall at step 4 for three cycles; stall in IDLE must be harmless.
    for (int s = 0; s < 11; s++) push(pulse_s[s], hold_s[s], step_s[s], 1'b0);
    push(4'b0000, 4'b0000, 3'd0, 1'b1);
    stall = 1'b1; start = 1'b1; intensity = INT_A;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin start = 1'b0; stall = 1'b0; end
      if (k == 5) stall = 1'b1;
      if (k == 8) stall = 1'b0;
      chk("b_ready", 32'(ready0), 32'(k == 12));
    end
    repeat (2) @(negedge clk);

    // Reset mid-frame: abort with no frame_done.
    for (int s = 0; s < 4; s++) push(pulse_a[s], hold_a[s], 3'(s), 1'b0);
    start = 1'b1; intensity = INT_A;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        rst = 1'b0;
        chk("d_ready",  32'(ready0 & ready1), 32'd1);
        chk("d_valid",  32'(valid0 | valid1), 32'd0);
        chk("d_spikes", 32'(spk0 | spk1), 32'd0);
        chk("d_step",   32'(step0 | step1), 32'd0);
      end
      if (k >= 5) chk("d_no_done", 32'(fd0 | fd1), 32'd0);
    end

    // Back-to-back: start held high, second frame has all-zero intensities.
    push_frame_a();
    for (int s = 0; s < 8; s++) push(4'b0000, 4'b0000, 3'(s), 1'b0);
    push(4'b0000, 4'b0000, 3'd0, 1'b1);
    start = 1'b1; intensity = INT_A;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 1) intensity = '0;
      if (k == 10) start = 1'b0;
      chk("e_ready", 32'(ready0), 32'(k == 9 || k == 18));
    end

    for (int w = 0; w < 20 && q.size() != 0; w++) @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
